urv_regfile_2r1w: RTL and testbench

Parametrised 2-read/1-write register file for the uRV core, holding the integer registers behind the decode/execute stages. It replaces the single-read-port, fixed 32x32 regfile with configurable width and depth and two independent asynchronous read ports for rs1/rs2. It adds hardwired-zero register 0, optional write-to-read bypass, and a post-reset clear sequencer, because distributed RAM cells have no reset.

---
 rtl/urv_regfile_2r1w.sv | 160 ++++++++++++++++
 tb/tb_urv_regfile_2r1w.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/urv_regfile_2r1w.sv
// ----------------------------------------------------------------------------
// urv_regfile_2r1w
//
// Integer register file for the uRV core: DEPTH x DATA_WIDTH storage with one
// synchronous write port and two independent asynchronous read ports (rs1/rs2).
// The storage array carries no reset so that it maps onto distributed RAM;
// instead, a clear sequencer walks every entry after reset and writes zero.
//
// Parameters
//   DATA_WIDTH      bits per register
//   ADDR_WIDTH      address bits, DEPTH = 2**ADDR_WIDTH
//   ZERO_REG        1: address 0 reads as zero and ignores writes
//   BYPASS          1: a read of the address being written returns wdata_i
//   CLEAR_ON_RESET  1: zero every entry after reset before accepting writes
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset
//   we_i       in   write enable
//   waddr_i    in   write address
//   wdata_i    in   write data
//   raddr_a_i  in   read port A address (rs1)
//   raddr_b_i  in   read port B address (rs2)
//   rdata_a_o  out  read port A data, combinational
//   rdata_b_o  out  read port B data, combinational
//   busy_o     out  high while in reset or clearing; writes are dropped
// ----------------------------------------------------------------------------
module urv_regfile_2r1w #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter bit          ZERO_REG       = 1'b1,
    parameter bit          BYPASS         = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    output logic                  busy_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;

    // Storage array: deliberately without reset.
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    busy_s;
    logic                    wr_cond_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_waddr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [DATA_WIDTH-1:0]   mem_a_s;
    logic [DATA_WIDTH-1:0]   mem_b_s;

    // Read-data priority: busy -> zero register -> bypass -> array contents.
    function automatic logic [DATA_WIDTH-1:0] read_sel(
        input logic                  busy,
        input logic [ADDR_WIDTH-1:0] raddr,
        input logic [DATA_WIDTH-1:0] mem_val,
        input logic                  wr_cond,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata
    );
        logic [DATA_WIDTH-1:0] res;
        if (busy) begin
            res = {DATA_WIDTH{1'b0}};
        end else if (ZERO_REG && (raddr == {ADDR_WIDTH{1'b0}})) begin
            res = {DATA_WIDTH{1'b0}};
        end else if (BYPASS && wr_cond && (raddr == waddr)) begin
            res = wdata;
        end else begin
            res = mem_val;
        end
        return res;
    endfunction

    // Control FSM: reset enters CLEAR (or READY), CLEAR walks every address once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_cnt_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1'b1);
                    if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= ST_READY;
                    end else begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_READY: begin
                    state_q   <= ST_READY;
                    clr_cnt_q <= clr_cnt_q;
                end
                default: begin
                    state_q   <= ST_READY;
                    clr_cnt_q <= {ADDR_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Busy/write-qualification: reset cycle counts as busy so writes are dropped.
    always_comb begin
        busy_s    = rst_i | (state_q != ST_READY);
        wr_cond_s = ~busy_s & we_i &
                    ~(ZERO_REG & (waddr_i == {ADDR_WIDTH{1'b0}}));
    end

    // Write-port mux: the clear sequencer owns the port while clearing.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = waddr_i;
        mem_wdata_s = wdata_i;
        if (rst_i) begin
            mem_we_s    = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_q;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
        end else begin
            mem_we_s    = wr_cond_s;
        end
    end

    // Synchronous array write.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Asynchronous array reads for both ports.
    always_comb begin
        mem_a_s = mem_q[raddr_a_i];
        mem_b_s = mem_q[raddr_b_i];
    end

    // Final read data and status outputs.
    always_comb begin
        rdata_a_o = read_sel(busy_s, raddr_a_i, mem_a_s, wr_cond_s, waddr_i, wdata_i);
        rdata_b_o = read_sel(busy_s, raddr_b_i, mem_b_s, wr_cond_s, waddr_i, wdata_i);
        busy_o    = busy_s;
    end

endmodule

// File: tb/tb_urv_regfile_2r1w.sv
// ----------------------------------------------------------------------------
// Testbench for urv_regfile_2r1w.
// dut1: default parameters (32x32, ZERO_REG, BYPASS, CLEAR_ON_RESET).
// dut2: 16x16, BYPASS=0, CLEAR_ON_RESET=0, with a reference model for traffic.
// Stimulus drives inputs 1 time unit after the rising edge and pushes the
// expected outputs for that cycle; the monitor pops and compares at the
// falling edge.
// ----------------------------------------------------------------------------
module tb_urv_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut1 signals
    logic        rst1, we1;
    logic [4:0]  wa1, ra1, rb1;
    logic [31:0] wd1, rda1, rdb1;
    logic        busy1;

    // dut2 signals
    logic        rst2, we2;
    logic [3:0]  wa2, ra2, rb2;
    logic [15:0] wd2, rda2, rdb2;
    logic        busy2;

    urv_regfile_2r1w dut1 (
        .clk_i     (clk),
        .rst_i     (rst1),
        .we_i      (we1),
        .waddr_i   (wa1),
        .wdata_i   (wd1),
        .raddr_a_i (ra1),
        .raddr_b_i (rb1),
        .rdata_a_o (rda1),
        .rdata_b_o (rdb1),
        .busy_o    (busy1)
    );

    urv_regfile_2r1w #(
        .DATA_WIDTH     (16),
        .ADDR_WIDTH     (4),
        .ZERO_REG       (1'b1),
        .BYPASS         (1'b0),
        .CLEAR_ON_RESET (1'b0)
    ) dut2 (
        .clk_i     (clk),
        .rst_i     (rst2),
        .we_i      (we2),
        .waddr_i   (wa2),
        .wdata_i   (wd2),
        .raddr_a_i (ra2),
        .raddr_b_i (rb2),
        .rdata_a_o (rda2),
        .rdata_b_o (rdb2),
        .busy_o    (busy2)
    );

    typedef struct {
        bit          sel;
        logic        busy;
        logic [31:0] a;
        logic [31:0] b;
        logic [95:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: compare DUT outputs against the queued expectation.
    exp_t        e;
    logic        act_busy;
    logic [31:0] act_a, act_b;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e        = sb_q.pop_front();
            act_busy = e.sel ? busy2 : busy1;
            act_a    = e.sel ? {16'h0, rda2} : rda1;
            act_b    = e.sel ? {16'h0, rdb2} : rdb1;
            checks++;
            if (act_busy !== e.busy) begin
                failures++;
                $display("FAIL %s busy: got %b want %b t=%0t", e.tag, act_busy, e.busy, $time);
            end
            checks++;
            if (act_a !== e.a) begin
                failures++;
                $display("FAIL %s rdata_a: got %h want %h t=%0t", e.tag, act_a, e.a, $time);
            end
            checks++;
            if (act_b !== e.b) begin
                failures++;
                $display("FAIL %s rdata_b: got %h want %h t=%0t", e.tag, act_b, e.b, $time);
            end
        end
    end

    // One cycle of stimulus for the selected DUT plus its expected response.
    task automatic cyc(input bit sel, input logic rst, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input logic xbusy, input logic [31:0] xa,
                       input logic [31:0] xb, input logic [95:0] tag);
        exp_t x;
        @(posedge clk);
        #1;
        if (!sel) begin
            rst1 = rst; we1 = we; wa1 = wa; wd1 = wd; ra1 = ra; rb1 = rb;
            we2  = 1'b0;
        end else begin
            rst2 = rst; we2 = we; wa2 = wa[3:0]; wd2 = wd[15:0];
            ra2  = ra[3:0]; rb2 = rb[3:0];
            we1  = 1'b0;
        end
        x.sel = sel; x.busy = xbusy; x.a = xa; x.b = xb; x.tag = tag;
        sb_q.push_back(x);
    endtask

    logic [15:0] m [16];
    logic        r_we;
    logic [3:0]  r_wa, r_ra, r_rb;
    logic [15:0] r_wd;
    logic [31:0] r_ea, r_eb;

    initial begin
        rst1 = 1'b1; we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0; ra1 = 5'd0; rb1 = 5'd0;
        rst2 = 1'b1; we2 = 1'b0; wa2 = 4'd0; wd2 = 16'd0; ra2 = 4'd0; rb2 = 4'd0;

        // ---------------- dut1: reset held 3 cycles, writes ignored ----------
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 1'b1, 5'(i + 1), 32'hFFFF0000, 5'(i + 1), 5'd31,
                1'b1, 32'd0, 32'd0, "rst_hold");

        // Clear: busy for exactly 32 cycles; writes at clear cycles 2 and 20 lost
        for (int i = 0; i <= 32; i++)
            cyc(1'b0, 1'b0, (i == 2) || (i == 20), (i == 2) ? 5'd3 : 5'd4,
                32'h00000055, 5'd3, 5'd4, (i < 32), 32'd0, 32'd0, "clear");

        for (int i = 0; i < 16; i++)
            cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i + 16),
                1'b0, 32'd0, 32'd0, "clr_read");

        // Write/read on both ports, with bypass in the write cycle
        cyc(1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd31, 1'b0, 32'hDEADBEEF, 32'd0, "wr5");
        cyc(1'b0, 1'b0, 1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31, 1'b0, 32'hDEADBEEF, 32'h12345678, "wr31");
        cyc(1'b0, 1'b0, 1'b0, 5'd0,  32'd0, 5'd5,  5'd31, 1'b0, 32'hDEADBEEF, 32'h12345678, "rd_5_31");
        cyc(1'b0, 1'b0, 1'b0, 5'd0,  32'd0, 5'd31, 5'd5,  1'b0, 32'h12345678, 32'hDEADBEEF, "rd_swap");

        // Zero register
        cyc(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, "zero_wr");
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 1'b0, 32'd0, 32'hDEADBEEF, "zero_rd");

        // Bypass, then the stored value, then bypass overriding an old value
        cyc(1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, "byp_wr7");
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, "byp_rd7");
        cyc(1'b0, 1'b0, 1'b1, 5'd5, 32'h0BADF00D, 5'd5, 5'd7, 1'b0, 32'h0BADF00D, 32'hA5A5A5A5, "byp_ovr5");
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 1'b0, 32'h0BADF00D, 32'hA5A5A5A5, "rd_ovr5");

        // Fill with garbage, confirm it is there
        for (int i = 1; i < 32; i++)
            cyc(1'b0, 1'b0, 1'b1, 5'(i), 32'hC0DE0000 + 32'(i), 5'(i), 5'd0,
                1'b0, 32'hC0DE0000 + 32'(i), 32'd0, "garbage");
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd10, 1'b0, 32'hC0DE0009, 32'hC0DE000A, "garb_rd");

        // Reset, then reset again at clear cycle 10: clear restarts fully
        cyc(1'b0, 1'b1, 1'b1, 5'd9, 32'h11111111, 5'd9, 5'd10, 1'b1, 32'd0, 32'd0, "rst2");
        for (int i = 0; i <= 10; i++)
            cyc(1'b0, (i == 10), 1'b0, 5'd0, 32'd0, 5'(i + 1), 5'd31,
                1'b1, 32'd0, 32'd0, "clear_a");
        for (int i = 0; i <= 32; i++)
            cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd30,
                (i < 32), 32'd0, 32'd0, "clear_b");
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i),
                1'b0, 32'd0, 32'd0, "clr2_read");

        // ---------------- dut2: no clear, no bypass, 16x16 -------------------
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b1, 32'd0, 32'd0, "d2_rst");
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, "d2_nobusy");
        m[0] = 16'h0000;
        for (int i = 1; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 5'(i), 32'h00001100 + 32'(i), 5'd0, 5'd0,
                1'b0, 32'd0, 32'd0, "d2_init");
            m[i] = 16'h1100 + 16'(i);
        end

        // No bypass: old value in the write cycle, new value afterwards
        cyc(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000A5A5, 5'd7, 5'd7, 1'b0, 32'h00001107, 32'h00001107, "d2_nobyp");
        m[7] = 16'hA5A5;
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b0, 32'h0000A5A5, 32'h0000A5A5, "d2_rd7");

        // Contents persist across reset; write during reset is dropped
        cyc(1'b1, 1'b1, 1'b1, 5'd2, 32'h0000BEEF, 5'd2, 5'd3, 1'b1, 32'd0, 32'd0, "d2_rst_wr");
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd3, 1'b0, 32'h00001102, 32'h00001103, "d2_persist");

        // Random traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            r_we = 1'($urandom_range(0, 1));
            r_wa = 4'($urandom_range(0, 15));
            r_wd = 16'($urandom_range(0, 65535));
            r_ra = 4'($urandom_range(0, 15));
            r_rb = 4'($urandom_range(0, 15));
            r_ea = (r_ra == 4'd0) ? 32'd0 : {16'h0, m[r_ra]};
            r_eb = (r_rb == 4'd0) ? 32'd0 : {16'h0, m[r_rb]};
            cyc(1'b1, 1'b0, r_we, {1'b0, r_wa}, {16'h0, r_wd}, {1'b0, r_ra}, {1'b0, r_rb},
                1'b0, r_ea, r_eb, "d2_rand");
            if (r_we && (r_wa != 4'd0)) m[r_wa] = r_wd;
        end

        // Drain the scoreboard with a bounded wait
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
